spill_seq_ctrl: RTL and testbench

SPILL_SEQ_CTRL -- requirements
Module: spill_seq_ctrl

---
 rtl/spill_seq_ctrl.sv | 102 ++++++++++
 tb/tb_spill_seq_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/spill_seq_ctrl.sv
// spill_seq_ctrl: spill sequencer IDLE->ARM->LIVE->DRAIN gating triggers to the DAQ.
// Optional LIVE timeout enabled by defining SPILL_TIMEOUT_EN.
module spill_seq_ctrl #(
  parameter int unsigned ARM_DLY   = 16,
  parameter int unsigned DRAIN_DLY = 64,
  parameter int unsigned TMO_CYC   = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sos_got,
  input  logic        eos_got,
  input  logic        trig_in,
  input  logic        daq_busy,
  output logic        catcher_rst,
  output logic        trig_en,
  output logic        trig_out,
  output logic        spill_active,
  output logic [1:0]  state,
  output logic [15:0] trig_cnt,
  output logic [15:0] drop_cnt,
  output logic        tmo_flag
);
  typedef enum logic [1:0] {IDLE, ARM, LIVE, DRAIN} state_t;
  state_t      state_q;
  logic [15:0] dly_q, trig_cnt_q, drop_cnt_q;
  logic        trig_out_q, catcher_rst_q;
  logic        accept, drop;
`ifdef SPILL_TIMEOUT_EN
  logic [23:0] tmo_q;
  logic        tmo_flag_q;
  assign tmo_flag = tmo_flag_q;
`else
  assign tmo_flag = (TMO_CYC == 0);
`endif
  assign accept       = state_q == LIVE && trig_in && !daq_busy;
  assign drop         = state_q == LIVE && trig_in && daq_busy;
  assign trig_en      = state_q == LIVE;
  assign spill_active = state_q != IDLE;
  assign state        = state_q;
  assign trig_cnt     = trig_cnt_q;
  assign drop_cnt     = drop_cnt_q;
  assign trig_out     = trig_out_q;
  assign catcher_rst  = catcher_rst_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      dly_q         <= '0;
      trig_cnt_q    <= '0;
      drop_cnt_q    <= '0;
      trig_out_q    <= 1'b0;
      catcher_rst_q <= 1'b0;
`ifdef SPILL_TIMEOUT_EN
      tmo_q         <= '0;
      tmo_flag_q    <= 1'b0;
`endif
    end else begin
      catcher_rst_q <= sos_got | eos_got;
      trig_out_q    <= accept;
      if (accept && trig_cnt_q != 16'hFFFF) trig_cnt_q <= trig_cnt_q + 16'd1;
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      case (state_q)
        IDLE: if (sos_got && !eos_got) begin
          state_q    <= ARM;
          dly_q      <= 16'(ARM_DLY - 1);
          trig_cnt_q <= '0;
          drop_cnt_q <= '0;
`ifdef SPILL_TIMEOUT_EN
          tmo_flag_q <= 1'b0;
`endif
        end
        ARM: if (eos_got) begin
          state_q <= DRAIN;
          dly_q   <= 16'(DRAIN_DLY - 1);
        end else if (dly_q == 16'd0) begin
          state_q <= LIVE;
`ifdef SPILL_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end else dly_q <= dly_q - 16'd1;
        LIVE: begin
`ifdef SPILL_TIMEOUT_EN
          if (eos_got) begin
            state_q <= DRAIN;
            dly_q   <= 16'(DRAIN_DLY - 1);
          end else if (tmo_q == 24'(TMO_CYC - 1)) begin
            state_q    <= DRAIN;
            dly_q      <= 16'(DRAIN_DLY - 1);
            tmo_flag_q <= 1'b1;
          end else tmo_q <= tmo_q + 24'd1;
`else
          if (eos_got) begin
            state_q <= DRAIN;
            dly_q   <= 16'(DRAIN_DLY - 1);
          end
`endif
        end
        DRAIN: if (dly_q != 16'd0) dly_q <= dly_q - 16'd1;
          else if (!daq_busy) state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spill_seq_ctrl.sv
// tb_spill_seq_ctrl: directed-vector bench for spill_seq_ctrl (ARM_DLY=16, DRAIN_DLY=64, TMO_CYC=100).
module tb_spill_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1, sos_got = 1'b0, eos_got = 1'b0, trig_in = 1'b0, daq_busy = 1'b0;
  logic catcher_rst, trig_en, trig_out, spill_active, tmo_flag;
  logic [1:0] state;
  logic [15:0] trig_cnt, drop_cnt;
  int passed = 0, total = 0;
  int n, tos;
  always #5 clk = ~clk;
  spill_seq_ctrl #(.ARM_DLY(16), .DRAIN_DLY(64), .TMO_CYC(100)) dut (
    .clk(clk), .rst(rst), .sos_got(sos_got), .eos_got(eos_got), .trig_in(trig_in),
    .daq_busy(daq_busy), .catcher_rst(catcher_rst), .trig_en(trig_en), .trig_out(trig_out),
    .spill_active(spill_active), .state(state), .trig_cnt(trig_cnt), .drop_cnt(drop_cnt),
    .tmo_flag(tmo_flag));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_state(input logic [1:0] s, output int cyc, output int outs);
    cyc = 0;
    outs = 0;
    do begin
      tick();
      cyc++;
      outs += int'(trig_out);
    end while (state != s && cyc < 1000);
  endtask
  task automatic go_live();
    sos_got = 1'b1;
    tick();
    sos_got = 1'b0;
    repeat (16) tick();
    chk("go_live_state", state, 2);
  endtask
  initial begin
    tick();
    chk("rst_state", state, 0);
    chk("rst_trig_cnt", trig_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_outs", {catcher_rst, trig_en, trig_out, spill_active, tmo_flag}, 0);
    rst = 1'b0;
    sos_got = 1'b1;
    tick();
    sos_got = 1'b0;
    chk("arm_state", state, 1);
    chk("arm_catcher_rst", catcher_rst, 1);
    chk("arm_spill_active", spill_active, 1);
    tick();
    chk("catcher_rst_one_cycle", catcher_rst, 0);
    repeat (14) tick();
    chk("arm_at_16", {state, trig_en}, {2'd1, 1'b0});
    tick();
    chk("live_at_17", {state, trig_en}, {2'd2, 1'b1});
    for (int i = 0; i < 5; i++) begin
      trig_in = 1'b1;
      tick();
      trig_in = 1'b0;
      chk("accept_trig_out", trig_out, 1);
      tick();
      chk("accept_trig_out_clr", trig_out, 0);
    end
    for (int i = 0; i < 3; i++) begin
      trig_in = 1'b1;
      daq_busy = 1'b1;
      tick();
      chk("busy_no_trig_out", trig_out, 0);
    end
    trig_in = 1'b0;
    daq_busy = 1'b0;
    chk("trig_cnt_5", trig_cnt, 5);
    chk("drop_cnt_3", drop_cnt, 3);
    eos_got = 1'b1;
    trig_in = 1'b1;
    tick();
    eos_got = 1'b0;
    chk("eos_live_drain", {state, trig_en}, {2'd3, 1'b0});
    chk("eos_same_cycle_accept", {trig_out, trig_cnt}, {1'b1, 16'd6});
    wait_state(2'd0, n, tos);
    trig_in = 1'b0;
    chk("live_drain_len", n, 64);
    chk("drain_no_trig_out", tos, 0);
    chk("idle_keeps_trig_cnt", trig_cnt, 6);
    sos_got = 1'b1;
    tick();
    sos_got = 1'b0;
    chk("rearm_clears_cnt", {trig_cnt, drop_cnt}, 0);
    repeat (3) tick();
    eos_got = 1'b1;
    tick();
    eos_got = 1'b0;
    chk("abort_drain", state, 3);
    chk("abort_catcher_rst", catcher_rst, 1);
    wait_state(2'd0, n, tos);
    chk("abort_drain_len", n, 64);
    chk("abort_trig_cnt", trig_cnt, 0);
    sos_got = 1'b1;
    tick();
    sos_got = 1'b0;
    eos_got = 1'b1;
    tick();
    eos_got = 1'b0;
    daq_busy = 1'b1;
    repeat (200) tick();
    chk("busy_hold_drain", state, 3);
    daq_busy = 1'b0;
    tick();
    chk("busy_release_idle", state, 0);
    sos_got = 1'b1;
    eos_got = 1'b1;
    tick();
    sos_got = 1'b0;
    eos_got = 1'b0;
    chk("glitch_stay_idle", state, 0);
    chk("glitch_catcher_rst", catcher_rst, 1);
    tick();
    chk("glitch_catcher_once", catcher_rst, 0);
    eos_got = 1'b1;
    tick();
    eos_got = 1'b0;
    chk("eos_idle_ignored", {state, catcher_rst}, {2'd0, 1'b1});
    go_live();
`ifdef SPILL_TIMEOUT_EN
    wait_state(2'd3, n, tos);
    chk("timeout_len", n, 100);
    chk("timeout_flag", tmo_flag, 1);
    wait_state(2'd0, n, tos);
    chk("timeout_flag_sticky", tmo_flag, 1);
    go_live();
    chk("timeout_flag_cleared", tmo_flag, 0);
`else
    repeat (150) tick();
    chk("no_timeout_state", state, 2);
    chk("no_timeout_flag", tmo_flag, 0);
`endif
    force dut.trig_cnt_q = 16'hFFFE;
    #1;
    release dut.trig_cnt_q;
    trig_in = 1'b1;
    repeat (3) tick();
    chk("trig_cnt_saturate", trig_cnt, 16'hFFFF);
    rst = 1'b1;
    tick();
    chk("mid_rst_state", state, 0);
    chk("mid_rst_cnts", {trig_cnt, drop_cnt}, 0);
    chk("mid_rst_outs", {trig_en, trig_out, spill_active, catcher_rst, tmo_flag}, 0);
    rst = 1'b0;
    trig_in = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
